// File: rtl/core_id_pipe.sv
// Decode stage with ID/EX pipeline register, load-use stall, flush and a
// write-first register file; held operands are refreshed by late write-backs.
module core_id_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_ex_valid,
  input  logic            i_ex_mem_read,
  input  logic [4:0]      i_ex_rd,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_rd_din,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_rs1_dout,
  output logic [XLEN-1:0] o_rs2_dout,
  output logic            o_illegal
);

  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic in_range(input logic [4:0] idx);
    return 32'(idx) < NREG;
  endfunction

  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic              uses_rs1, uses_rs2, writes_rd, known_op;
  logic signed [31:0] imm;
  logic              illegal, hazard, wr_en, load_en;
  logic [XLEN-1:0]   rs1_data, rs2_data;
  logic [XLEN-1:0]   rf [NREG];

  assign opcode = i_instr[6:0];
  assign rd     = i_instr[11:7];
  assign rs1    = i_instr[19:15];
  assign rs2    = i_instr[24:20];

  // Operand usage and immediate format per base opcode
  always_comb begin : decode
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    known_op  = 1'b1;
    imm       = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        uses_rs1 = 1'b0;
        imm      = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        uses_rs1 = 1'b0;
        imm      = 32'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_MISC, OP_SYSTEM:
        imm = 32'($signed(i_instr[31:20]));
      OP_STORE: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
        imm       = 32'($signed({i_instr[31:25], i_instr[11:7]}));
      end
      OP_BRANCH: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
        imm       = 32'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
      end
      OP_OP:
        uses_rs2 = 1'b1;
      default: begin
        known_op  = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  assign illegal = ~known_op
                 | (uses_rs1  & ~in_range(rs1))
                 | (uses_rs2  & ~in_range(rs2))
                 | (writes_rd & ~in_range(rd));

  assign hazard = i_valid & i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0)
                & ((uses_rs1 & (rs1 == i_ex_rd)) | (uses_rs2 & (rs2 == i_ex_rd)));

  assign o_ready = i_flush | ((~o_valid | i_ready) & ~hazard);
  assign load_en = ~o_valid | i_ready;
  assign wr_en   = i_wb_reg_write & (i_wb_rd != 5'd0) & in_range(i_wb_rd);

  // Register file storage; x0 is a constant zero entry
  assign rf[0] = '0;
  for (genvar g = 1; g < NREG; g++) begin : g_rf
    logic [XLEN-1:0] q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        q <= '0;
      else if (wr_en && (i_wb_rd == 5'(g)))
        q <= i_rd_din;
    end
    assign rf[g] = q;
  end

  // Write-first read ports
  always_comb begin : rf_read
    rs1_data = in_range(rs1) ? rf[AW'(rs1)] : '0;
    rs2_data = in_range(rs2) ? rf[AW'(rs2)] : '0;
    if (wr_en && (i_wb_rd == rs1)) rs1_data = i_rd_din;
    if (wr_en && (i_wb_rd == rs2)) rs2_data = i_rd_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : id_ex
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_pc       <= '0;
      o_opcode   <= '0;
      o_funct3   <= '0;
      o_funct7   <= '0;
      o_rd       <= '0;
      o_rs1      <= '0;
      o_rs2      <= '0;
      o_imm      <= '0;
      o_rs1_dout <= '0;
      o_rs2_dout <= '0;
      o_illegal  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (load_en) begin
      o_valid <= i_valid & ~hazard;
      if (i_valid && !hazard) begin
        o_pc       <= i_pc;
        o_opcode   <= opcode;
        o_funct3   <= i_instr[14:12];
        o_funct7   <= i_instr[31:25];
        o_rd       <= rd;
        o_rs1      <= rs1;
        o_rs2      <= rs2;
        o_imm      <= known_op ? XLEN'(imm) : '0;
        o_rs1_dout <= rs1_data;
        o_rs2_dout <= rs2_data;
        o_illegal  <= illegal;
      end
    end else begin
      // Held payload: pick up a write-back that lands while EX is stalled
      if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == o_rs1)) o_rs1_dout <= i_rd_din;
      if (i_wb_reg_write && (i_wb_rd != 5'd0) && (i_wb_rd == o_rs2)) o_rs2_dout <= i_rd_din;
    end
  end

endmodule

// File: tb/tb_core_id_pipe.sv
// Directed bench for core_id_pipe: RV32I instance plus an RV32E instance on
// the same stimulus for the NREG=16 corner cases.
module tb_core_id_pipe;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] ADDI_X1_X0_M3 = 32'hFFD0_0093;
  localparam logic [31:0] SW_X1_8_X2    = 32'h0011_2423;
  localparam logic [31:0] ADD_X9_X5_X0  = 32'h0002_84B3;
  localparam logic [31:0] ADD_X4_X3_X1  = 32'h0011_8233;
  localparam logic [31:0] LUI_X3_18     = 32'h0001_81B7;
  localparam logic [31:0] ADD_X8_X7_X0  = 32'h0003_8433;
  localparam logic [31:0] ADD_X17_X1_X2 = 32'h0020_88B3;
  localparam logic [31:0] ADD_X9_X4_X0  = 32'h0002_04B3;
  localparam logic [31:0] BAD_OPCODE    = 32'h0000_000B;

  logic            i_clk = 1'b0;
  logic            i_rst_n, i_valid, i_flush, i_ex_valid, i_ex_mem_read;
  logic            i_wb_reg_write, i_ready;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc, i_rd_din;
  logic [4:0]      i_ex_rd, i_wb_rd;

  logic            a_ready, a_valid, a_illegal;
  logic [XLEN-1:0] a_pc, a_imm, a_rs1_dout, a_rs2_dout;
  logic [6:0]      a_opcode, a_funct7;
  logic [2:0]      a_funct3;
  logic [4:0]      a_rd, a_rs1, a_rs2;

  logic            e_ready, e_valid, e_illegal;
  logic [XLEN-1:0] e_pc, e_imm, e_rs1_dout, e_rs2_dout;
  logic [6:0]      e_opcode, e_funct7;
  logic [2:0]      e_funct3;
  logic [4:0]      e_rd, e_rs1, e_rs2;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  core_id_pipe #(.XLEN(XLEN), .NREG(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(a_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_ex_valid(i_ex_valid),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd), .i_wb_reg_write(i_wb_reg_write),
    .i_wb_rd(i_wb_rd), .i_rd_din(i_rd_din), .o_valid(a_valid), .i_ready(i_ready),
    .o_pc(a_pc), .o_opcode(a_opcode), .o_funct3(a_funct3), .o_funct7(a_funct7),
    .o_rd(a_rd), .o_rs1(a_rs1), .o_rs2(a_rs2), .o_imm(a_imm),
    .o_rs1_dout(a_rs1_dout), .o_rs2_dout(a_rs2_dout), .o_illegal(a_illegal)
  );

  core_id_pipe #(.XLEN(XLEN), .NREG(16)) dut_e (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(e_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .i_ex_valid(i_ex_valid),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd), .i_wb_reg_write(i_wb_reg_write),
    .i_wb_rd(i_wb_rd), .i_rd_din(i_rd_din), .o_valid(e_valid), .i_ready(i_ready),
    .o_pc(e_pc), .o_opcode(e_opcode), .o_funct3(e_funct3), .o_funct7(e_funct7),
    .o_rd(e_rd), .o_rs1(e_rs1), .o_rs2(e_rs2), .o_imm(e_imm),
    .o_rs1_dout(e_rs1_dout), .o_rs2_dout(e_rs2_dout), .o_illegal(e_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ex_valid = 1'b0;
    i_ex_mem_read = 1'b0; i_ex_rd = 5'd0; i_wb_reg_write = 1'b0; i_wb_rd = 5'd0;
    i_rd_din = '0; i_ready = 1'b1; i_instr = '0; i_pc = '0;

    #12;
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_imm", a_imm, 32'd0);
    i_rst_n = 1'b1;
    step();

    // Back-to-back streaming
    i_valid = 1'b1; i_instr = ADDI_X1_X0_M3; i_pc = 32'h100;
    step();
    check("addi_valid", 32'(a_valid), 32'd1);
    check("addi_imm", a_imm, 32'hFFFF_FFFD);
    check("addi_rd", 32'(a_rd), 32'd1);
    check("addi_op", 32'(a_opcode), 32'h13);
    check("addi_pc", a_pc, 32'h100);
    i_instr = SW_X1_8_X2; i_pc = 32'h104;
    step();
    check("sw_valid", 32'(a_valid), 32'd1);
    check("sw_imm", a_imm, 32'h8);
    check("sw_rs1", 32'(a_rs1), 32'd2);
    check("sw_rs2", 32'(a_rs2), 32'd1);
    check("sw_funct3", 32'(a_funct3), 32'd2);
    check("sw_pc", a_pc, 32'h104);
    i_valid = 1'b0;
    step();
    check("drain_valid", 32'(a_valid), 32'd0);

    // Register write, read-back, then reset mid-stream clears everything
    i_wb_reg_write = 1'b1; i_wb_rd = 5'd5; i_rd_din = 32'h55;
    step();
    i_wb_reg_write = 1'b0; i_valid = 1'b1; i_instr = ADD_X9_X5_X0; i_pc = 32'h200;
    step();
    check("x5_read", a_rs1_dout, 32'h55);
    #1 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_valid), 32'd0);
    check("mid_rst_pc", a_pc, 32'd0);
    check("mid_rst_rs1d", a_rs1_dout, 32'd0);
    check("mid_rst_rd", 32'(a_rd), 32'd0);
    i_rst_n = 1'b1;
    step();
    check("post_rst_valid", 32'(a_valid), 32'd1);
    check("post_rst_x5", a_rs1_dout, 32'd0);

    // Load-use stall
    i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd3;
    i_instr = ADD_X4_X3_X1; i_pc = 32'h300;
    #1 check("lu_ready", 32'(a_ready), 32'd0);
    step();
    check("lu_bubble", 32'(a_valid), 32'd0);
    i_ex_valid = 1'b0;
    #1 check("lu_ready_clr", 32'(a_ready), 32'd1);
    step();
    check("lu_valid", 32'(a_valid), 32'd1);
    check("lu_rd", 32'(a_rd), 32'd4);
    check("lu_pc", a_pc, 32'h300);
    i_ex_valid = 1'b1; i_instr = LUI_X3_18; i_pc = 32'h304;
    #1 check("lui_ready", 32'(a_ready), 32'd1);
    step();
    check("lui_valid", 32'(a_valid), 32'd1);
    check("lui_imm", a_imm, 32'h0001_8000);
    check("lui_rd", 32'(a_rd), 32'd3);
    i_ex_valid = 1'b0; i_ex_mem_read = 1'b0;

    // Same-cycle bypass, then refresh while held
    i_instr = ADD_X8_X7_X0; i_pc = 32'h400;
    i_wb_reg_write = 1'b1; i_wb_rd = 5'd7; i_rd_din = 32'hDEAD;
    step();
    check("byp_rs1d", a_rs1_dout, 32'hDEAD);
    check("byp_rs1", 32'(a_rs1), 32'd7);
    i_valid = 1'b0; i_ready = 1'b0; i_wb_reg_write = 1'b0;
    #1 check("hold_ready", 32'(a_ready), 32'd0);
    step();
    check("hold_valid", 32'(a_valid), 32'd1);
    check("hold_rs1d", a_rs1_dout, 32'hDEAD);
    i_wb_reg_write = 1'b1; i_rd_din = 32'hBEEF;
    step();
    check("ref_rs1d", a_rs1_dout, 32'hBEEF);
    check("ref_rs2d", a_rs2_dout, 32'd0);
    check("ref_rd", 32'(a_rd), 32'd8);
    check("ref_pc", a_pc, 32'h400);
    check("ref_valid", 32'(a_valid), 32'd1);
    i_wb_reg_write = 1'b0;

    // Flush beats both the stall and the hazard
    i_valid = 1'b1; i_instr = ADD_X4_X3_X1; i_pc = 32'h500;
    i_ex_valid = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd3; i_flush = 1'b1;
    #1 check("flush_ready", 32'(a_ready), 32'd1);
    step();
    check("flush_valid", 32'(a_valid), 32'd0);
    i_flush = 1'b0; i_valid = 1'b0; i_ex_valid = 1'b0; i_ex_mem_read = 1'b0;
    step();
    check("flush_drop", 32'(a_valid), 32'd0);

    // RV32E index limits
    i_ready = 1'b1; i_valid = 1'b1; i_instr = ADD_X17_X1_X2; i_pc = 32'h600;
    step();
    check("e_x17_illegal", 32'(e_illegal), 32'd1);
    check("e_x17_valid", 32'(e_valid), 32'd1);
    check("a_x17_legal", 32'(a_illegal), 32'd0);
    i_valid = 1'b0; i_wb_reg_write = 1'b1; i_wb_rd = 5'd20; i_rd_din = 32'h1234;
    step();
    i_wb_reg_write = 1'b0; i_valid = 1'b1; i_instr = ADD_X9_X4_X0; i_pc = 32'h604;
    step();
    check("e_x4_read", e_rs1_dout, 32'd0);
    check("e_x4_legal", 32'(e_illegal), 32'd0);
    i_wb_reg_write = 1'b1; i_wb_rd = 5'd20; i_rd_din = 32'h5678;
    step();
    check("e_x4_alias_byp", e_rs1_dout, 32'd0);
    check("a_x4_read", a_rs1_dout, 32'd0);
    i_wb_reg_write = 1'b0; i_instr = BAD_OPCODE; i_pc = 32'h608;
    step();
    check("e_bad_op", 32'(e_illegal), 32'd1);
    check("a_bad_op", 32'(a_illegal), 32'd1);
    check("a_bad_op_valid", 32'(a_valid), 32'd1);
    i_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
